// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with optional
// write-to-read bypass and a per-register pending scoreboard. Decode uses
// the scoreboard to detect RAW hazards.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_pend,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREGS-1:0]      pend_vec
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pend;

    logic [AW-1:0]    rd_a;
    logic [XLEN-1:0]  rd_v;

    // Storage update; later write ports are applied last so the highest
    // index wins on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0)) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Pending scoreboard: retiring writes clear, the issue sets afterwards so
    // a newer producer issued in the same cycle keeps the bit high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    pend[wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (iss_en) begin
                pend[iss_addr] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                pend[0] <= 1'b0;
            end
        end
    end

    // Combinational read ports with optional same-cycle bypass; forced to
    // zero while reset is held so writes presented during reset never leak.
    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        rd_a    = '0;
        rd_v    = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_a = rd_addr[k*AW +: AW];
            rd_v = mem[rd_a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == rd_a) begin
                        rd_v = wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            if (ZERO_REG != 0 && rd_a == '0) begin
                rd_v = '0;
            end
            if (rst) begin
                rd_v = '0;
            end
            rd_data[k*XLEN +: XLEN] = rd_v;
            rd_pend[k]              = rst ? 1'b0 : pend[rd_a];
        end
    end

    assign pend_vec = pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: default build driven from a vector table, plus a
// BYPASS=0 / NRD=4 / XLEN=64 / NREGS=16 build for the no-bypass case.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // default build
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] pend_vec;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_vec (pend_vec)
    );

    // no-bypass wide build
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_pend;
    logic [1:0]   b_wr_en;
    logic [7:0]   b_wr_addr;
    logic [127:0] b_wr_data;
    logic         b_iss_en;
    logic [3:0]   b_iss_addr;
    logic [15:0]  b_pend_vec;

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_pend  (b_rd_pend),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .iss_en   (b_iss_en),
        .iss_addr (b_iss_addr),
        .pend_vec (b_pend_vec)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ep;
        logic [31:0] epv;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Applied at negedge; outputs checked 1ns later (before the posedge),
        // so each row sees the state left by the previous row.
        vecs[0]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,  2'b00, 32'h0};
        vecs[1]  = '{2'b11, 5'd1,  5'd2,  32'd10,       32'd20,  1'b0, 5'd0,  5'd1,  5'd2,  32'd10,       32'd20, 2'b00, 32'h0};
        vecs[2]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd1,  5'd2,  32'd10,       32'd20, 2'b00, 32'h0};
        vecs[3]  = '{2'b11, 5'd3,  5'd3,  32'h11,       32'h22,  1'b0, 5'd0,  5'd3,  5'd1,  32'h22,       32'd10, 2'b00, 32'h0};
        vecs[4]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd3,  5'd3,  32'h22,       32'h22, 2'b00, 32'h0};
        vecs[5]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,   1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,  2'b00, 32'h0};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd0,  5'd1,  32'h0,        32'd10, 2'b00, 32'h0};
        vecs[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b1, 5'd7,  5'd7,  5'd1,  32'h0,        32'd10, 2'b00, 32'h0};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd7,  5'd2,  32'h0,        32'd20, 2'b01, 32'h80};
        vecs[9]  = '{2'b10, 5'd0,  5'd7,  32'h0,        32'h55,  1'b1, 5'd7,  5'd7,  5'd2,  32'h55,       32'd20, 2'b01, 32'h80};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd7,  5'd7,  32'h55,       32'h55, 2'b11, 32'h80};
        vecs[11] = '{2'b01, 5'd7,  5'd0,  32'h66,       32'h0,   1'b0, 5'd0,  5'd7,  5'd1,  32'h66,       32'd10, 2'b01, 32'h80};
        vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd7,  5'd1,  32'h66,       32'd10, 2'b00, 32'h0};
        vecs[13] = '{2'b01, 5'd10, 5'd0,  32'hA,        32'h0,   1'b1, 5'd9,  5'd9,  5'd10, 32'h0,        32'hA,  2'b00, 32'h0};
        vecs[14] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd9,  5'd10, 32'h0,        32'hA,  2'b01, 32'h200};
        vecs[15] = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h99,  1'b0, 5'd0,  5'd9,  5'd10, 32'h99,       32'hA,  2'b01, 32'h200};
        vecs[16] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd9,  5'd3,  32'h99,       32'h22, 2'b00, 32'h0};
        vecs[17] = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,   1'b1, 5'd12, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,  2'b00, 32'h0};
        vecs[18] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0, 5'd0,  5'd5,  5'd12, 32'hDEADBEEF, 32'h0,  2'b10, 32'h1000};

        rst      = 1'b1;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        b_rd_addr  = '0;
        b_wr_en    = '0;
        b_wr_addr  = '0;
        b_wr_data  = '0;
        b_iss_en   = 1'b0;
        b_iss_addr = '0;

        // reset state
        #2;
        check("reset_rd_data", rd_data, 64'h0);
        check("reset_rd_pend", {62'h0, rd_pend}, 64'h0);
        check("reset_pend_vec", {32'h0, pend_vec}, 64'h0);
        check("reset_b_pend_vec", {48'h0, b_pend_vec}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            wr_en    = vecs[i].we;
            wr_addr  = {vecs[i].wa1, vecs[i].wa0};
            wr_data  = {vecs[i].wd1, vecs[i].wd0};
            iss_en   = vecs[i].ie;
            iss_addr = vecs[i].ia;
            rd_addr  = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("v%0d_rd0", i), {32'h0, rd_data[31:0]},  {32'h0, vecs[i].e0});
            check($sformatf("v%0d_rd1", i), {32'h0, rd_data[63:32]}, {32'h0, vecs[i].e1});
            check($sformatf("v%0d_pend", i), {62'h0, rd_pend}, {62'h0, vecs[i].ep});
            check($sformatf("v%0d_pvec", i), {32'h0, pend_vec}, {32'h0, vecs[i].epv});
            @(negedge clk);
        end

        // asynchronous reset mid-run, no clock edge between assert and check
        wr_en   = '0;
        iss_en  = 1'b0;
        rd_addr = {5'd6, 5'd5};
        #1;
        check("prerst_x5", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("rst_x5_now", {32'h0, rd_data[31:0]}, 64'h0);
        check("rst_pvec_now", {32'h0, pend_vec}, 64'h0);
        // writes and issues during reset are ignored, even for bypass
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd6};
        wr_data  = {32'h0, 32'h77};
        iss_en   = 1'b1;
        iss_addr = 5'd6;
        #1;
        check("rst_x6_bypass", {32'h0, rd_data[63:32]}, 64'h0);
        check("rst_pend6", {62'h0, rd_pend}, 64'h0);
        @(negedge clk);
        wr_en  = '0;
        iss_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("post_rst_x5", {32'h0, rd_data[31:0]}, 64'h0);
        check("post_rst_x6", {32'h0, rd_data[63:32]}, 64'h0);
        check("post_rst_pvec", {32'h0, pend_vec}, 64'h0);
        @(negedge clk);
        check("post_rst_x5_edge", {32'h0, rd_data[31:0]}, 64'h0);

        // no-bypass build: all four ports read x4 while it is written
        b_wr_en   = 2'b01;
        b_wr_addr = {4'd0, 4'd4};
        b_wr_data = {64'h0, 64'h1_0000_0000};
        b_rd_addr = {4'd4, 4'd4, 4'd4, 4'd4};
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_same_cyc_p%0d", k), b_rd_data[k*64 +: 64], 64'h0);
        end
        @(negedge clk);
        b_wr_en = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_next_cyc_p%0d", k), b_rd_data[k*64 +: 64], 64'h1_0000_0000);
        end
        // collision on x5 without bypass: old value now, port 1 value after
        @(negedge clk);
        b_wr_en   = 2'b11;
        b_wr_addr = {4'd5, 4'd5};
        b_wr_data = {64'h2, 64'h1};
        b_rd_addr = {4'd0, 4'd4, 4'd5, 4'd5};
        #1;
        check("b_coll_same", b_rd_data[63:0], 64'h0);
        @(negedge clk);
        b_wr_en = '0;
        #1;
        check("b_coll_next", b_rd_data[63:0], 64'h2);
        check("b_coll_p2_x4", b_rd_data[128 +: 64], 64'h1_0000_0000);
        check("b_pvec", {48'h0, b_pend_vec}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
